// File: rtl/rect_offset_generator.sv
// Rectangle hit test and in-object offsets against a frame-latched top-left,
// with a start gate on the first frame and frame-counted blinking.
module rect_offset_generator #(
    parameter int OBJECT_WIDTH  = 64,
    parameter int OBJECT_HEIGHT = 16,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic [10:0] topLeftX,
    input  logic [10:0] topLeftY,
    input  logic        visibleEnable,
    input  logic        blinkEnable,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        blinkPhase
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);
    localparam logic [11:0] W_LIM = 12'(OBJECT_WIDTH);
    localparam logic [11:0] H_LIM = 12'(OBJECT_HEIGHT);

    typedef enum logic {
        WAIT_FRAME,
        ACTIVE
    } state_t;

    state_t          state_q, state_d;
    logic [10:0]     shadow_x_q, shadow_x_d;
    logic [10:0]     shadow_y_q, shadow_y_d;
    logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic            blink_en_q, blink_en_d;
    logic            inside_q, inside_d;
    logic [10:0]     off_x_q, off_x_d;
    logic [10:0]     off_y_q, off_y_d;

    logic [11:0]     dx;
    logic [11:0]     dy;
    logic            hit;

    // Signed 12-bit differences; a set MSB means the pixel is left/above the object.
    always_comb begin
        dx  = {1'b0, pixelX} - {shadow_x_q[10], shadow_x_q};
        dy  = {1'b0, pixelY} - {shadow_y_q[10], shadow_y_q};
        hit = !dx[11] && (dx < W_LIM) && !dy[11] && (dy < H_LIM);
    end

    always_comb begin
        state_d    = state_q;
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        if (startOfFrame) begin
            state_d    = ACTIVE;
            shadow_x_d = topLeftX;
            shadow_y_d = topLeftY;
        end
    end

    // The rising edge of blinkEnable restarts blinking in the shown phase.
    always_comb begin
        blink_en_d    = blinkEnable;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!blinkEnable || !blink_en_q) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (startOfFrame) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        inside_d = (state_q == ACTIVE) && hit && visibleEnable
                   && (blink_phase_q || !blinkEnable);
        off_x_d  = inside_d ? dx[10:0] : 11'd0;
        off_y_d  = inside_d ? dy[10:0] : 11'd0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= WAIT_FRAME;
            shadow_x_q    <= '0;
            shadow_y_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            blink_en_q    <= 1'b0;
            inside_q      <= 1'b0;
            off_x_q       <= '0;
            off_y_q       <= '0;
        end else begin
            state_q       <= state_d;
            shadow_x_q    <= shadow_x_d;
            shadow_y_q    <= shadow_y_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            blink_en_q    <= blink_en_d;
            inside_q      <= inside_d;
            off_x_q       <= off_x_d;
            off_y_q       <= off_y_d;
        end
    end

    assign InsideRectangle = inside_q;
    assign offsetX         = off_x_q;
    assign offsetY         = off_y_q;
    assign blinkPhase      = blink_phase_q;

endmodule

// File: tb/tb_rect_offset_generator.sv
// Directed-vector bench for rect_offset_generator (64x16 object, 2-frame blink).
module tb_rect_offset_generator;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        visibleEnable;
    logic        blinkEnable;
    logic        InsideRectangle;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        blinkPhase;

    int n_vec  = 0;
    int n_miss = 0;

    rect_offset_generator #(
        .OBJECT_WIDTH (64),
        .OBJECT_HEIGHT(16),
        .BLINK_FRAMES (2)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .startOfFrame   (startOfFrame),
        .topLeftX       (topLeftX),
        .topLeftY       (topLeftY),
        .visibleEnable  (visibleEnable),
        .blinkEnable    (blinkEnable),
        .InsideRectangle(InsideRectangle),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .blinkPhase     (blinkPhase)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
        tick();
    endtask

    task automatic sof(input int x, input int y);
        topLeftX     = 11'(x);
        topLeftY     = 11'(y);
        startOfFrame = 1'b1;
        pix(600, 400);
        startOfFrame = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({InsideRectangle, offsetX, offsetY, blinkPhase} !== 24'd0) begin
            n_miss++;
            $display("FAIL reset_outputs got %h want 0",
                     {InsideRectangle, offsetX, offsetY, blinkPhase});
        end
        pix(100, 50);
        pix(101, 50);
        n_vec++;
        if ({InsideRectangle, offsetX, offsetY, blinkPhase} !== 24'd0) begin
            n_miss++;
            $display("FAIL reset_held got %h want 0",
                     {InsideRectangle, offsetX, offsetY, blinkPhase});
        end
        #3 resetN = 1'b1;
    endtask

    task automatic test_wait_frame();
        int hits;
        hits     = 0;
        topLeftX = 11'd100;
        topLeftY = 11'd50;
        for (int y = 46; y < 70; y++) begin
            for (int x = 96; x < 168; x++) begin
                pix(x, y);
                if (InsideRectangle !== 1'b0) hits++;
            end
        end
        n_vec++;
        if (hits !== 0) begin
            n_miss++;
            $display("FAIL wait_frame_hits got %0d want 0", hits);
        end
        n_vec++;
        if (blinkPhase !== 1'b1) begin
            n_miss++;
            $display("FAIL idle_blink_phase got %b want 1", blinkPhase);
        end
    endtask

    task automatic test_hit();
        int px [6] = '{100, 163, 164, 163, 99, 100};
        int py [6] = '{50, 65, 65, 66, 50, 49};
        logic [22:0] ex [6] = '{{1'b1, 11'd0, 11'd0}, {1'b1, 11'd63, 11'd15},
                                23'd0, 23'd0, 23'd0, 23'd0};
        sof(100, 50);
        for (int i = 0; i < 6; i++) begin
            pix(px[i], py[i]);
            n_vec++;
            if ({InsideRectangle, offsetX, offsetY} !== ex[i]) begin
                n_miss++;
                $display("FAIL hit_%0d got %h want %h", i,
                         {InsideRectangle, offsetX, offsetY}, ex[i]);
            end
        end
    endtask

    task automatic test_shadow();
        logic [22:0] ex [5] = '{{1'b1, 11'd0, 11'd0}, 23'd0, {1'b1, 11'd0, 11'd0},
                                23'd0, {1'b1, 11'd0, 11'd0}};
        logic [22:0] got [5];
        topLeftX = 11'd200;
        pix(100, 50);
        got[0] = {InsideRectangle, offsetX, offsetY};
        pix(200, 50);
        got[1] = {InsideRectangle, offsetX, offsetY};
        startOfFrame = 1'b1;
        pix(100, 50);
        startOfFrame = 1'b0;
        got[2] = {InsideRectangle, offsetX, offsetY};
        pix(100, 50);
        got[3] = {InsideRectangle, offsetX, offsetY};
        pix(200, 50);
        got[4] = {InsideRectangle, offsetX, offsetY};
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (got[i] !== ex[i]) begin
                n_miss++;
                $display("FAIL shadow_%0d got %h want %h", i, got[i], ex[i]);
            end
        end
    endtask

    task automatic test_negative();
        int px [4] = '{0, 53, 54, 0};
        int py [4] = '{0, 11, 0, 12};
        logic [22:0] ex [4] = '{{1'b1, 11'd10, 11'd4}, {1'b1, 11'd63, 11'd15},
                                23'd0, 23'd0};
        sof(-10, -4);
        for (int i = 0; i < 4; i++) begin
            pix(px[i], py[i]);
            n_vec++;
            if ({InsideRectangle, offsetX, offsetY} !== ex[i]) begin
                n_miss++;
                $display("FAIL negative_%0d got %h want %h", i,
                         {InsideRectangle, offsetX, offsetY}, ex[i]);
            end
        end
    endtask

    task automatic test_visible();
        visibleEnable = 1'b0;
        pix(5, 5);
        n_vec++;
        if ({InsideRectangle, offsetX, offsetY} !== 23'd0) begin
            n_miss++;
            $display("FAIL visible_off got %h want 0",
                     {InsideRectangle, offsetX, offsetY});
        end
        visibleEnable = 1'b1;
        pix(5, 5);
        n_vec++;
        if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd15, 11'd9}) begin
            n_miss++;
            $display("FAIL visible_on got %h want %h",
                     {InsideRectangle, offsetX, offsetY}, {1'b1, 11'd15, 11'd9});
        end
    endtask

    task automatic test_blink();
        logic ex [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        sof(100, 50);
        blinkEnable = 1'b1;
        pix(600, 400);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) sof(100, 50);
            pix(100, 50);
            n_vec++;
            if ({InsideRectangle, blinkPhase} !== {ex[k], ex[k]}) begin
                n_miss++;
                $display("FAIL blink_frame_%0d got %b%b want %b%b", k,
                         InsideRectangle, blinkPhase, ex[k], ex[k]);
            end
        end
        blinkEnable = 1'b0;
        pix(100, 50);
        n_vec++;
        if ({InsideRectangle, blinkPhase} !== 2'b11) begin
            n_miss++;
            $display("FAIL blink_drop got %b%b want 11",
                     InsideRectangle, blinkPhase);
        end
        blinkEnable = 1'b1;
        sof(100, 50);
        sof(100, 50);
        pix(100, 50);
        n_vec++;
        if ({InsideRectangle, blinkPhase} !== 2'b11) begin
            n_miss++;
            $display("FAIL blink_rise_with_sof got %b%b want 11",
                     InsideRectangle, blinkPhase);
        end
        sof(100, 50);
        pix(100, 50);
        n_vec++;
        if ({InsideRectangle, blinkPhase} !== 2'b00) begin
            n_miss++;
            $display("FAIL blink_after_rise got %b%b want 00",
                     InsideRectangle, blinkPhase);
        end
        blinkEnable = 1'b0;
        pix(600, 400);
    endtask

    task automatic test_reset_mid();
        int hits;
        hits = 0;
        pix(100, 50);
        n_vec++;
        if (InsideRectangle !== 1'b1) begin
            n_miss++;
            $display("FAIL pre_reset_inside got %b want 1", InsideRectangle);
        end
        #2 resetN = 1'b0;
        #1;
        n_vec++;
        if ({InsideRectangle, offsetX, offsetY, blinkPhase} !== 24'd0) begin
            n_miss++;
            $display("FAIL async_reset got %h want 0",
                     {InsideRectangle, offsetX, offsetY, blinkPhase});
        end
        #1 resetN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pix(100 + i, 50);
            if (InsideRectangle !== 1'b0) hits++;
        end
        startOfFrame = 1'b1;
        pix(100, 50);
        startOfFrame = 1'b0;
        if (InsideRectangle !== 1'b0) hits++;
        n_vec++;
        if (hits !== 0) begin
            n_miss++;
            $display("FAIL post_reset_hits got %0d want 0", hits);
        end
        pix(110, 52);
        n_vec++;
        if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd10, 11'd2}) begin
            n_miss++;
            $display("FAIL post_reset_redraw got %h want %h",
                     {InsideRectangle, offsetX, offsetY}, {1'b1, 11'd10, 11'd2});
        end
    endtask

    initial begin
        resetN        = 1'b0;
        pixelX        = '0;
        pixelY        = '0;
        startOfFrame  = 1'b0;
        topLeftX      = '0;
        topLeftY      = '0;
        visibleEnable = 1'b1;
        blinkEnable   = 1'b0;
        test_reset();
        test_wait_frame();
        test_hit();
        test_shadow();
        test_negative();
        test_visible();
        test_blink();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rect_offset_generator.md
Name: rect_offset_generator

Overview:
- Coordinate-side producer for the fixed-size sprite bitmap units (64x16 "TIME" label and similar). It generates the InsideRectangle / offsetX / offsetY stream that a bitmap unit consumes.
- Converts the VGA scan position plus the object's top-left into registered rectangle-hit and offset signals.
- Latches the position once per frame to prevent tearing, holds off drawing until the first frame boundary, and provides frame-counted blinking.

Parameters:
- OBJECT_WIDTH, 64, sprite width in pixels; 1..1024.
- OBJECT_HEIGHT, 16, sprite height in pixels; 1..1024.
- BLINK_FRAMES, 30, frames per blink half-period; >=1.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  reset
- pixelX  in  11  current scan column, unsigned 0..639
- pixelY  in  11  current scan row, unsigned 0..479
- startOfFrame  in  1  one-cycle pulse, issued in vertical blanking after the last visible line
- topLeftX  in  11  requested object left edge, signed two's complement (negative = partly off-screen)
- topLeftY  in  11  requested object top edge, signed two's complement
- visibleEnable  in  1  1 = object may be drawn
- blinkEnable  in  1  1 = blinking active
- InsideRectangle  out  1  registered: the pixel from the previous cycle lies inside the object
- offsetX  out  11  registered column offset inside the object; 0 when outside
- offsetY  out  11  registered row offset inside the object; 0 when outside
- blinkPhase  out  1  current blink phase; 1 = shown

Behaviour:
- Reset: resetN is asynchronous, active-low; clock is clk.
  - During reset all outputs are 0 (InsideRectangle, offsetX, offsetY, blinkPhase).
  - Shadow position = (0,0), frame counter = 0, state = WAIT_FRAME.
- State machine: two states, WAIT_FRAME and ACTIVE.
  - WAIT_FRAME -> ACTIVE on the first startOfFrame. There is no other transition.
  - In WAIT_FRAME, InsideRectangle is forced to 0.
- Shadow position:
  - topLeftX/topLeftY are copied into shadow registers on the clk edge where startOfFrame=1.
  - Hit tests use the shadow values only.
  - A startOfFrame cycle still tests against the old shadow values; the new values apply from the following cycle.
  - topLeft changes between pulses have no visible effect.
- Geometry, computed in 12-bit signed:
  - dx = {0,pixelX} - sext(shadowX); dy likewise.
  - hit = (0 <= dx < OBJECT_WIDTH) && (0 <= dy < OBJECT_HEIGHT). The right and bottom edges are exclusive.
  - Negative shadow values clip correctly. Example: shadowX = -10 makes column pixelX=0 produce offsetX=10.
- Output registration, latency 1 cycle:
  - InsideRectangle <= ACTIVE && hit && visibleEnable && (blinkPhase || !blinkEnable).
  - offsetX/offsetY <= dx[10:0]/dy[10:0] when that Inside term is 1, else 0.
- Blink counter:
  - While blinkEnable=0: counter held at 0 and blinkPhase held at 1.
  - While blinkEnable=1: each startOfFrame increments the counter. When it reaches BLINK_FRAMES-1, the next pulse wraps it to 0 and toggles blinkPhase.
  - The clock edge where blinkEnable goes 0->1 clears the counter and sets blinkPhase=1. Blinking therefore always starts in the shown phase.
  - If blinkEnable rises in the same cycle as startOfFrame, the clear wins.
- Reset mid-frame: outputs drop to 0 immediately. Nothing is drawn until the next startOfFrame after reset release.
- visibleEnable is not registered before use; it acts on the pixel being evaluated in that same cycle.

Test Plan:
- Reset release, scan a full frame with topLeft=(100,50) before any startOfFrame -> InsideRectangle=0 for the whole frame.
- startOfFrame, topLeft=(100,50), pixel (100,50) at cycle N -> at N+1: Inside=1, offsets (0,0). Pixel (163,65) -> Inside=1, offsets (63,15). Pixels (164,65) and (163,66) -> Inside=0, offsets (0,0).
- topLeft changed to (200,50) mid-frame, pixel (100,50) -> still hit until the next startOfFrame. After that pulse, (100,50) misses and (200,50) hits.
- topLeft=(-10,-4) latched, pixel (0,0) -> Inside=1, offsetX=10, offsetY=4. Pixel (54,0) -> Inside=0.
- BLINK_FRAMES=2, blinkEnable=1, object in view -> shown for 2 frames, hidden for 2, shown for 2. Dropping blinkEnable -> shown at once and blinkPhase=1.
- resetN pulsed low mid-line while Inside=1 -> outputs go to 0 asynchronously and stay 0 until the next startOfFrame after release.
